// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: a one-cycle-latency SRAM feeding a 2-entry {pc, inst} FIFO, with redirect flush.
// Optional IF_ALIGN_CHECK_EN: misaligned fetches skip the SRAM and are presented with an if_adel flag.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        if_adel
`endif
);

  logic [31:0] fpc_q, fpc_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pc_fifo_q   [2];
  logic [31:0] inst_fifo_q [2];

  logic        deq;
  logic        enq;
  logic        fetch;
  logic        misaligned;
  logic        wr_ptr;
  logic [2:0]  occ;
  logic [31:0] enq_inst;

`ifdef IF_ALIGN_CHECK_EN
  logic req_adel_q;
  logic adel_fifo_q [2];
`endif

  assign inst_sram_wen = 4'b0000;

  always_comb begin
    if_valid       = (count_q != 2'd0) & ~redirect_valid;
    deq            = if_valid & id_ready;
    // Occupancy counts the inflight word so the FIFO can never be overrun.
    occ            = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
    fetch          = ~rst & (redirect_valid | (occ < 3'd2));
    inst_sram_addr = redirect_valid ? redirect_pc : fpc_q;
`ifdef IF_ALIGN_CHECK_EN
    misaligned     = |inst_sram_addr[1:0];
    enq_inst       = req_adel_q ? 32'h0 : inst_sram_rdata;
`else
    misaligned     = 1'b0;
    enq_inst       = inst_sram_rdata;
`endif
    inst_sram_en   = fetch & ~misaligned;
    // A response arriving during a redirect belongs to the old path and is dropped.
    enq            = inflight_q & ~redirect_valid;
    wr_ptr         = rd_ptr_q ^ count_q[0];

    fpc_d      = fetch ? (inst_sram_addr + 32'd4) : fpc_q;
    inflight_d = fetch;
    req_pc_d   = inst_sram_addr;
    if (redirect_valid) begin
      count_d  = 2'd0;
      rd_ptr_d = rd_ptr_q;
    end else begin
      count_d  = count_q + {1'b0, enq} - {1'b0, deq};
      rd_ptr_d = rd_ptr_q ^ deq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      req_pc_q   <= 32'h0;
      for (int i = 0; i < 2; i++) begin
        pc_fifo_q[i]   <= 32'h0;
        inst_fifo_q[i] <= 32'h0;
      end
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      req_pc_q   <= req_pc_d;
      if (enq) begin
        pc_fifo_q[wr_ptr]   <= req_pc_q;
        inst_fifo_q[wr_ptr] <= enq_inst;
      end
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_adel_q     <= 1'b0;
      adel_fifo_q[0] <= 1'b0;
      adel_fifo_q[1] <= 1'b0;
    end else begin
      req_adel_q <= misaligned;
      if (enq) adel_fifo_q[wr_ptr] <= req_adel_q;
    end
  end

  assign if_adel = if_valid & adel_fifo_q[rd_ptr_q];
`endif

  assign if_pc   = pc_fifo_q[rd_ptr_q];
  assign if_inst = inst_fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stimulus queues expected accepted PCs, a negedge monitor checks them.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef IF_ALIGN_CHECK_EN
  logic        if_adel;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .if_adel         (if_adel)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address A is ~A; idle cycles return junk so mistimed captures show up.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? ~inst_sram_addr : 32'hdeadbeef;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_accept: got pc %h want none", if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("acc_pc", if_pc, mon_e);
        chk("acc_inst", if_inst, ~mon_e);
      end
    end
  end

  initial begin
    push_seq(32'hbfc00000, 13);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", {31'h0, inst_sram_en}, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("wen", {28'h0, inst_sram_wen}, 32'h0);
    tick();
    rst = 1'b0;

    // cycles 0..2: consecutive fetches, first valid two cycles after the first fetch
    @(negedge clk);
    chk("c0_en", {31'h0, inst_sram_en}, 32'h1);
    chk("c0_addr", inst_sram_addr, 32'hbfc00000);
    chk("c0_valid", {31'h0, if_valid}, 32'h0);
    tick();
    @(negedge clk);
    chk("c1_addr", inst_sram_addr, 32'hbfc00004);
    chk("c1_valid", {31'h0, if_valid}, 32'h0);
    tick();
    @(negedge clk);
    chk("c2_addr", inst_sram_addr, 32'hbfc00008);
    chk("c2_valid", {31'h0, if_valid}, 32'h1);
    chk("c2_pc", if_pc, 32'hbfc00000);
    tick();
    repeat (7) tick();

    // cycles 10..14: decode stalls, FIFO fills, fetching stops, head held
    id_ready = 1'b0;
    @(negedge clk);
    chk("stall_en0", {31'h0, inst_sram_en}, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_en", {31'h0, inst_sram_en}, 32'h0);
      chk("stall_valid", {31'h0, if_valid}, 32'h1);
      chk("stall_pc", if_pc, 32'hbfc00020);
      chk("stall_inst", if_inst, ~32'hbfc00020);
      tick();
    end
    id_ready = 1'b1;
    repeat (5) tick();

    // cycle 20: redirect with a word inflight and one queued
    push_seq(32'hbfc00100, 4);
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc00100;
    @(negedge clk);
    chk("redir_en", {31'h0, inst_sram_en}, 32'h1);
    chk("redir_addr", inst_sram_addr, 32'hbfc00100);
    chk("redir_valid", {31'h0, if_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    @(negedge clk);
    chk("redir_flushed", {31'h0, if_valid}, 32'h0);
    tick();
    repeat (4) tick();

    // cycle 26: redirect in a cycle that would otherwise dequeue
    push_seq(32'hbfc00200, 3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc00200;
    @(negedge clk);
    chk("rdq_valid", {31'h0, if_valid}, 32'h0);
    chk("rdq_addr", inst_sram_addr, 32'hbfc00200);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rdq_empty", {31'h0, if_valid}, 32'h0);
    tick();
    repeat (3) tick();

    // cycle 31: fetch PC wraps past the top of the address space
    push_seq(32'hfffffff8, 4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hfffffff8;
    @(negedge clk);
    chk("wrap_addr0", inst_sram_addr, 32'hfffffff8);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addr1", inst_sram_addr, 32'hfffffffc);
    tick();
    @(negedge clk);
    chk("wrap_addr2", inst_sram_addr, 32'h00000000);
    repeat (4) tick();

    // cycle 37: asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    chk("arst_en", {31'h0, inst_sram_en}, 32'h0);
    chk("arst_valid", {31'h0, if_valid}, 32'h0);
    chk("arst_pc", if_pc, 32'h0);
    chk("arst_inst", if_inst, 32'h0);
    tick();
    tick();
    push_seq(32'hbfc00000, 5);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_addr", inst_sram_addr, 32'hbfc00000);
    chk("restart_en", {31'h0, inst_sram_en}, 32'h1);
    tick();
    repeat (6) tick();
    id_ready = 1'b0;
    repeat (2) tick();

`ifdef IF_ALIGN_CHECK_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc00102;
    @(negedge clk);
    chk("adel_en", {31'h0, inst_sram_en}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("adel_valid", {31'h0, if_valid}, 32'h1);
    chk("adel_flag", {31'h0, if_adel}, 32'h1);
    chk("adel_inst", if_inst, 32'h0);
    chk("adel_pc", if_pc, 32'hbfc00102);
    tick();
`endif

    chk("leftover", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
